// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, RV32I width codes and access-legality check for the load/store unit.
package lsu_pkg;
   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   // High when the access is misaligned for its width or not a legal RV32I load/store width.
   function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] lo);
      return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]) ||
             ((f3 == F3_H || f3 == F3_HU) && lo[0]) || (f3 == F3_W && lo != 2'b00);
   endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte/half lane merge for stores and sign/zero-extending lane extract for loads.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  lane,
   input  logic [2:0]  funct3,
   output logic [31:0] merged,
   output logic [31:0] extracted
);
   logic [4:0]  sh;
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      sh = {lane, 3'b000};
      b = 8'(word >> sh);
      h = lane[1] ? word[31:16] : word[15:0];
      extracted = funct3 == F3_B  ? {{24{b[7]}}, b} :
                  funct3 == F3_H  ? {{16{h[15]}}, h} :
                  funct3 == F3_BU ? {24'b0, b} :
                  funct3 == F3_HU ? {16'b0, h} : word;
      merged = funct3 == F3_B ? (word & ~(32'hFF << sh)) | ({24'b0, wdata[7:0]} << sh) :
               funct3 == F3_H ? (lane[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]}) :
               wdata;
   end
endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: request/response load/store unit for a word-wide data memory;
// sub-word stores are done by read-modify-write, illegal or misaligned accesses are rejected.
module data_mem_lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              mem_ce,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);
   state_t state, state_n;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        f3_q;
   logic              we_q;
   logic [31:0]       wdata_q, word_q, merged, extracted;
   logic              req_err;

   assign req_err = access_err(req_we, req_funct3, req_addr[1:0]);

   lsu_align u_align (
      .word      (state == READ ? mem_rdata : word_q),
      .wdata     (wdata_q),
      .lane      (addr_q[1:0]),
      .funct3    (f3_q),
      .merged    (merged),
      .extracted (extracted)
   );

   // Memory-side outputs come straight from the state register so reset kills them at once.
   assign req_ready = state == IDLE;
   assign rsp_valid = state == RESP;
   assign mem_ce    = state == READ || state == WRITE;
   assign mem_wr_en = state == WRITE;
   assign mem_addr  = mem_ce ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign mem_wdata = mem_wr_en ? merged : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = req_valid ? (req_err ? RESP : READ) : IDLE;
         READ:    state_n = we_q ? WRITE : RESP;
         WRITE:   state_n = RESP;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q    <= '0;
         f3_q      <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         word_q    <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (state == IDLE && req_valid) begin
            addr_q  <= req_addr;
            f3_q    <= req_funct3;
            we_q    <= req_we;
            wdata_q <= req_wdata;
            if (req_err) begin
               rsp_rdata <= '0;
               rsp_err   <= 1'b1;
            end
         end
         if (state == READ) begin
            word_q <= mem_rdata;
            if (!we_q) begin
               rsp_rdata <= extracted;
               rsp_err   <= 1'b0;
            end
         end
         if (state == WRITE) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
         end
      end
   end
endmodule
